// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, operands shifted LSB first, carry held in a flop.
// Result is assembled in a shift register and published on sum/c_out for one done cycle.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  logic [1:0]       state, state_next;
  logic             busy_next, done_next;
  logic [WIDTH-1:0] sh_a, sh_b, res;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             bit_s, carry_next;
  logic             last_bit;

  // The single full-adder cell
  assign bit_s      = sh_a[0] ^ sh_b[0] ^ carry;
  assign carry_next = (sh_a[0] & sh_b[0]) | ((sh_a[0] ^ sh_b[0]) & carry);
  assign last_bit   = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= busy_next;
      done  <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    busy_next  = 1'b0;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          busy_next  = 1'b1;
        end
      end
      RUN: begin
        if (last_bit) begin
          state_next = FIN;
          done_next  = 1'b1;
        end else begin
          busy_next  = 1'b1;
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, bit sequencing and result publication
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_a  <= '0;
      sh_b  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      c_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sh_a  <= a;
            sh_b  <= b;
            carry <= c_in;
            cnt   <= '0;
          end
        end
        RUN: begin
          sh_a  <= {1'b0, sh_a[WIDTH-1:1]};
          sh_b  <= {1'b0, sh_b[WIDTH-1:1]};
          res   <= {bit_s, res[WIDTH-1:1]};
          carry <= carry_next;
          // Counter holds at LAST instead of wrapping
          if (!last_bit) begin
            cnt <= cnt + CW'(1);
          end else begin
            sum   <= {bit_s, res[WIDTH-1:1]};
            c_out <= carry_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=8): driver pushes expected {c_out,sum}, monitor pops on done.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       c_in = 1'b0;
  logic       busy, done, c_out;
  logic [7:0] sum;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc_last = 0;
  int done_cyc_prev = 0;
  logic [8:0] exp_q[$];

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c_in(c_in),
    .busy(busy), .done(done), .sum(sum), .c_out(c_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: compares each completion against the scoreboard
  always @(negedge clk) begin
    if (!rst && done) begin
      done_cnt++;
      done_cyc_prev = done_cyc_last;
      done_cyc_last = cyc;
      check("busy_low_during_done", int'(busy), 0);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        check("result", int'({c_out, sum}), int'(exp_q.pop_front()));
      end
    end
  end

  // Issue one addition, check busy length and done latency
  task automatic do_add(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                        input logic [8:0] expv);
    int n;
    int bc;
    a = va; b = vb; c_in = vc; start = 1'b1;
    exp_q.push_back(expv);
    @(negedge clk);
    start = 1'b0;
    n = 0; bc = 0;
    while (!done && n < 30) begin
      if (busy) bc++;
      @(negedge clk);
      n++;
    end
    check("done_latency", n, 8);
    check("busy_cycles", bc, 8);
    @(negedge clk);
    check("done_one_cycle", int'(done), 0);
  endtask

  initial begin
    int n;
    int base;
    repeat (2) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_sum_cout", int'({c_out, sum}), 0);
    rst = 1'b0;
    @(negedge clk);

    do_add(8'h35, 8'h4A, 1'b0, 9'h07F);
    do_add(8'hFF, 8'h01, 1'b0, 9'h100);
    do_add(8'hFF, 8'hFF, 1'b1, 9'h1FF);
    do_add(8'h00, 8'h00, 1'b1, 9'h001);
    do_add(8'hA5, 8'h5A, 1'b0, 9'h0FF);

    // Start and operand changes mid-run must not disturb the in-flight addition
    base = done_cnt;
    a = 8'h12; b = 8'h34; c_in = 1'b0; start = 1'b1;
    exp_q.push_back(9'h046);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'hAA; b = 8'h55; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 8'hFF; b = 8'hFF; c_in = 1'b1;
    n = 0;
    while (done_cnt == base && n < 30) begin @(negedge clk); n++; end
    repeat (12) @(negedge clk);
    check("midrun_single_done", done_cnt - base, 1);
    check("midrun_sum_held", int'({c_out, sum}), 9'h046);

    // Reset mid-operation abandons the addition
    base = done_cnt;
    a = 8'h80; b = 8'h80; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_done", int'(done), 0);
    check("async_rst_sum_cout", int'({c_out, sum}), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("no_done_after_rst", done_cnt - base, 0);
    do_add(8'h80, 8'h80, 1'b0, 9'h100);

    // Start held high: back-to-back additions every WIDTH+2 cycles
    base = done_cnt;
    a = 8'h01; b = 8'h02; c_in = 1'b0; start = 1'b1;
    exp_q.push_back(9'h003);
    exp_q.push_back(9'h007);
    @(negedge clk);
    a = 8'h03; b = 8'h04;
    n = 0;
    while (done_cnt == base && n < 30) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    check("held_first_sum", int'({c_out, sum}), 9'h003);
    n = 0;
    while (done_cnt < base + 2 && n < 30) begin @(negedge clk); n++; end
    start = 1'b0;
    check("held_two_dones", done_cnt - base, 2);
    check("held_done_spacing", done_cyc_last - done_cyc_prev, 10);
    repeat (14) @(negedge clk);
    check("held_second_sum", int'({c_out, sum}), 9'h007);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
